// File: rtl/product_boxcar_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : product_boxcar_decimator
//  Description : Integrate-and-dump averager for the signed IQ product
//                stream. Sums 2^k consecutive samples and emits their mean
//                once per block, with a one-cycle valid strobe. The block
//                exponent k is programmable at runtime; values above
//                MAXLOG2N are clamped.
//
//  Build option: BOXCAR_ROUND_EN
//                defined   -> mean = (sum + 2^(k-1)) >>> k for k>0
//                             (round half toward +infinity)
//                undefined -> mean = sum >>> k (floor)
//
//  Parameters  : INBITS   - signed sample / mean width
//                MAXLOG2N - largest block exponent (1..31)
//
//  Ports       : clk_i     - system clock, rising edge
//                rst_i     - synchronous active-high reset
//                signal_i  - signed product sample, taken every edge
//                log2_n_i  - block exponent k (N = 2^k)
//                clear_i   - synchronous restart of the current block
//                signal_o  - signed block mean, held between blocks
//                valid_o   - one-cycle strobe when signal_o updates
//
//  Revision    : 1.0 - initial release
// ============================================================================
module product_boxcar_decimator #(
  parameter int INBITS   = 14,
  parameter int MAXLOG2N = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [INBITS-1:0] signal_i,
  input  logic [4:0]               log2_n_i,
  input  logic                     clear_i,
  output logic signed [INBITS-1:0] signal_o,
  output logic                     valid_o
);

  // N * 2^(INBITS-1) always fits, so the accumulator cannot overflow.
  localparam int         c_acc_w = INBITS + MAXLOG2N;
  localparam logic [4:0] c_k_max = 5'(MAXLOG2N);

  // State registers
  logic [4:0]                k_q,      k_d;
  logic [MAXLOG2N-1:0]       cnt_q,    cnt_d;
  logic signed [c_acc_w-1:0] acc_q,    acc_d;
  logic signed [INBITS-1:0]  signal_q, signal_d;
  logic                      valid_q,  valid_d;

  // Combinational helpers
  logic [4:0]                w_k_eff;
  logic                      w_restart;
  logic [MAXLOG2N-1:0]       w_last_cnt;
  logic signed [c_acc_w-1:0] w_sum;
  logic signed [c_acc_w-1:0] w_sum_r;
  logic signed [c_acc_w-1:0] w_scaled;

  always_comb begin
    w_k_eff   = (log2_n_i > c_k_max) ? c_k_max : log2_n_i;
    w_restart = clear_i || (w_k_eff != k_q);

    // N-1 as a mask of k_q ones; a shift by the full width yields all ones.
    w_last_cnt = ~({MAXLOG2N{1'b1}} << k_q);

    // Size cast of a signed operand sign-extends the sample.
    w_sum = acc_q + c_acc_w'(signal_i);

`ifdef BOXCAR_ROUND_EN
    // Adding half an LSB of the result before the floor shift rounds
    // half toward +infinity. The sum plus N/2 still fits the accumulator.
    if (k_q == 5'd0) begin
      w_sum_r = w_sum;
    end else begin
      w_sum_r = w_sum + (c_acc_w'(1) << (k_q - 5'd1));
    end
`else
    w_sum_r = w_sum;
`endif

    // The mean of INBITS-wide samples always lies in the INBITS range,
    // so simple truncation of the shifted sum is exact.
    w_scaled = w_sum_r >>> k_q;
  end

  always_comb begin
    k_d      = k_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    signal_d = signal_q;
    valid_d  = 1'b0;

    if (w_restart) begin
      // The sample presented in the restart cycle is dropped.
      k_d   = w_k_eff;
      acc_d = '0;
      cnt_d = '0;
    end else if (cnt_q == w_last_cnt) begin
      // Dump: the Nth sample is folded in on the same edge.
      signal_d = INBITS'(w_scaled);
      valid_d  = 1'b1;
      acc_d    = '0;
      cnt_d    = '0;
    end else begin
      acc_d = w_sum;
      cnt_d = cnt_q + MAXLOG2N'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q      <= w_k_eff;
      cnt_q    <= '0;
      acc_q    <= '0;
      signal_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      signal_q <= signal_d;
      valid_q  <= valid_d;
    end
  end

  assign signal_o = signal_q;
  assign valid_o  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_product_boxcar_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_boxcar_decimator
//  Description : Scoreboard bench for product_boxcar_decimator. A block-level
//                reference model predicts each block mean and the edge on
//                which it must appear; a monitor compares DUT outputs.
//                Honours BOXCAR_ROUND_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_product_boxcar_decimator;

  localparam int INBITS   = 14;
  localparam int MAXLOG2N = 10;

  logic                     clk;
  logic                     rst;
  logic signed [INBITS-1:0] sig_in;
  logic [4:0]               log2_n;
  logic                     clr;
  logic signed [INBITS-1:0] sig_out;
  logic                     valid;

  product_boxcar_decimator #(
    .INBITS   (INBITS),
    .MAXLOG2N (MAXLOG2N)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .signal_i (sig_in),
    .log2_n_i (log2_n),
    .clear_i  (clr),
    .signal_o (sig_out),
    .valid_o  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int edge_n;
    int val;
  } exp_t;

  exp_t q[$];
  bit   rst_edge[int];

  // ---------------- reference model (block level) ----------------
  int     m_k = 0;
  longint m_sum = 0;
  int     m_n = 0;

  function automatic int mean_of(longint s, int k);
    longint r;
`ifdef BOXCAR_ROUND_EN
    if (k > 0) r = (s + (longint'(1) << (k - 1))) >>> k;
    else       r = s;
`else
    r = s >>> k;
`endif
    return int'(r);
  endfunction

  task automatic model_step(input bit r, input bit c, input int k_in,
                            input int s, input int e);
    int keff;
    keff = (k_in > MAXLOG2N) ? MAXLOG2N : k_in;
    if (r) begin
      m_k = keff; m_sum = 0; m_n = 0;
      rst_edge[e] = 1'b1;
    end else if (c || keff != m_k) begin
      m_k = keff; m_sum = 0; m_n = 0;
    end else begin
      m_sum += s;
      m_n++;
      if (m_n == (1 << m_k)) begin
        q.push_back('{edge_n: e, val: mean_of(m_sum, m_k)});
        m_sum = 0; m_n = 0;
      end
    end
  endtask

  // One clock of stimulus: model sees exactly what the DUT samples next edge.
  task automatic cyc(input bit r, input bit c, input int k, input int s);
    rst    = r;
    clr    = c;
    log2_n = 5'(k);
    sig_in = INBITS'(s);
    model_step(r, c, k, s, edge_cnt + 1);
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  // ---------------- monitor ----------------
  int held = 0;

  always @(negedge clk) begin
    if (edge_cnt >= 1) begin
      while (q.size() > 0 && q[0].edge_n < edge_cnt) begin
        checks++; errors++;
        $display("FAIL missed_valid: expected mean %0d at edge %0d, no valid_o seen",
                 q[0].val, q[0].edge_n);
        void'(q.pop_front());
      end
      if (rst_edge.exists(edge_cnt)) begin
        checks++;
        if (valid !== 1'b0 || sig_out !== '0) begin
          errors++;
          $display("FAIL reset_state: edge %0d got signal_o=%0d valid_o=%b, required 0/0",
                   edge_cnt, sig_out, valid);
        end
        held = 0;
      end else if (valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: edge %0d valid_o=1 signal_o=%0d, none expected",
                   edge_cnt, sig_out);
        end else if (q[0].edge_n != edge_cnt) begin
          errors++;
          $display("FAIL valid_timing: valid_o at edge %0d, required edge %0d",
                   edge_cnt, q[0].edge_n);
        end else begin
          exp_t x;
          x = q.pop_front();
          if (int'(sig_out) != x.val) begin
            errors++;
            $display("FAIL block_mean: edge %0d signal_o=%0d, required %0d",
                     edge_cnt, sig_out, x.val);
          end
          held = x.val;
        end
      end else begin
        checks++;
        if (valid !== 1'b0 || int'(sig_out) != held) begin
          errors++;
          $display("FAIL hold_value: edge %0d signal_o=%0d valid_o=%b, required %0d/0",
                   edge_cnt, sig_out, valid, held);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst = 1'b1; clr = 1'b0; log2_n = 5'd2; sig_in = '0;

    // Reset held 3 cycles with a nonzero sample, then constant 100 at k=2.
    for (int i = 0; i < 3; i++) cyc(1, 0, 2, 500);
    for (int i = 0; i < 12; i++) cyc(0, 0, 2, 100);

    // k=0: continuous valid, one-cycle delayed copy.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, rnd_sample());

    // Rounding, positive sum 7 over 4.
    cyc(0, 1, 2, 0);
    cyc(0, 0, 2, 1); cyc(0, 0, 2, 2); cyc(0, 0, 2, 2); cyc(0, 0, 2, 2);

    // Rounding, negative sum -7 over 2.
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, -3); cyc(0, 0, 1, -4);

    // Extremes at k=3.
    cyc(0, 1, 3, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 3, 8191);
    for (int i = 0; i < 8; i++) cyc(0, 0, 3, -8192);

    // Mid-block exponent change; 999 is dropped.
    for (int i = 0; i < 5; i++) cyc(0, 0, 3, rnd_sample());
    cyc(0, 0, 1, 999);
    cyc(0, 0, 1, 40); cyc(0, 0, 1, -13);

    // clear_i pulse mid-block.
    cyc(0, 1, 2, 0);
    cyc(0, 0, 2, 7); cyc(0, 0, 2, 9);
    cyc(0, 1, 2, 5000);
    for (int i = 0; i < 8; i++) cyc(0, 0, 2, rnd_sample());

    // Reset mid-block discards the partial sum.
    cyc(0, 0, 2, 33);
    cyc(1, 0, 2, 33);
    for (int i = 0; i < 8; i++) cyc(0, 0, 2, rnd_sample());

    // Clamped exponent: 31 behaves as MAXLOG2N.
    for (int i = 0; i < 2100; i++) cyc(0, 0, 31, rnd_sample());

    // Random mix of exponents, clears and occasional resets.
    k = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) k = int'($urandom_range(0, 6));
      if ($urandom_range(0, 999) == 0) k = 31;
      cyc(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
          k, rnd_sample());
    end

    // Drain with restarts so nothing further is expected.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected results left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
